fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the multicycle MIPS core: owns the program counter, the instruction register and the next-PC selection, and sits directly under the multicycle controller, consuming its `pcwr`, `irwr` and `npc_sel` strobes. It presents a word address to the instruction ROM, latches the returned word into the IR, and supplies `instr` back to the controller and the datapath. It also provides the link value for `jal`/`bltzal`, a sticky misaligned-target flag and a retired-fetch counter for bring-up.

## Interface
- `RESET_PC`, 32'h0000_3000, PC value after reset.
- `IM_AW`, 10, instruction ROM word-address width.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `pcwr`  in  1  PC write enable from the controller.
- `irwr`  in  1  IR write enable from the controller.
- `npc_sel`  in  2  next-PC source: 00 PC+4, 01 branch, 10 jump, 11 register (jr).
- `rs_data`  in  32  GPR[rs] from the register file; the jr target.
- `imem_rdata`  in  32  combinational ROM read data for `imem_addr`.
- `imem_addr`  out  IM_AW  ROM word address, equal to `pc[IM_AW+1:2]`.
- `instr`  out  32  IR contents.
- `pc`  out  32  current PC.
- `link`  out  32  return address for jal/bltzal; equals `pc`, which is already fetch-PC+4 after S0.
- `misalign`  out  1  sticky: a PC write with target[1:0] != 0 was rejected.
- `fetch_cnt`  out  32  number of IR loads since reset.

## Operation
- Next-PC (combinational), all from pre-edge values:
  - 00: `pc + 4`.
  - 01: `pc + {{14{instr[15]}}, instr[15:0], 2'b00}`. `pc` already points past the branch.
  - 10: `{pc[31:28], instr[25:0], 2'b00}`.
  - 11: `rs_data`.
- `npc_sel` is meaningful only when `pcwr`=1. With `pcwr`=0 its value, including X, has no effect on any state.
- On a `pcwr` edge with `npc[1:0]`==0, `pc` <= `npc`.
- On a `pcwr` edge with `npc[1:0]`!=0, `pc` holds and `misalign` sets to 1. `misalign` clears only on reset. Only the 11 (jr) path can produce this case.
- `irwr` edge: `instr` <= `imem_rdata`; `fetch_cnt` <= `fetch_cnt`+1, wrapping 32'hFFFF_FFFF -> 0.
- `pcwr` and `irwr` together (controller state S0): IR takes the word at the old PC and PC takes old PC+4, both sampled before the edge.
- `pc` and IR bits above the ROM range are not checked; the ROM aliases addresses above its size.

## Timing
- Reset values: `pc`=RESET_PC, `instr`=0, `misalign`=0, `fetch_cnt`=0, `imem_addr`=`RESET_PC[IM_AW+1:2]`.
- `imem_addr` follows `pc` combinationally with zero latency. The ROM is combinational, so the IR is valid one edge after `irwr`.
- Reset asserted mid-instruction: all state returns immediately, asynchronously, to reset values. The first fetch after release reads RESET_PC.
- No handshake or stall: every strobe takes effect on the same edge at which it is sampled high.

## Structure
- Shared package `mips_pkg`:
  - `npc_sel` encodings `NPC_PC4`, `NPC_BR`, `NPC_J`, `NPC_JR`.
  - Default `RESET_PC`.
  - Any controller state constants the core shares.
- Sub-module `npc`: purely combinational next-PC and alignment check, with inputs `pc`, `instr`, `rs_data`, `npc_sel` and outputs `npc`, `npc_misaligned`.
- Registers (PC, IR, flag, counter) stay in `fetch_unit`.

## Test plan
- **Reset and fetch:** reset, release, then one cycle of `pcwr`=`irwr`=1, `npc_sel`=00, ROM[0]=32'h3401_0005. Required: `instr`=32'h3401_0005, `pc`=32'h3004, `fetch_cnt`=1.
- **Branch:** `pc`=32'h3008, IR=beq with imm 16'hFFFE, `pcwr`=1, `npc_sel`=01. Required: `pc`=32'h3000. Repeat with `pcwr`=0: `pc` stays 32'h3008.
- **Jump:** `pc`=32'h3010, IR=j with target 26'h0000C10, `npc_sel`=10. Required: `pc`=32'h0000_3040.
- **jr, aligned and misaligned:** jr with `rs_data`=32'h3020 gives `pc`=32'h3020. A following jr with `rs_data`=32'h3022 leaves `pc`=32'h3020 and sets `misalign`=1, which stays 1 across later fetches until reset.
- **Asynchronous reset mid-run:** assert `rst` between clock edges after 5 fetches. Required: `pc`=32'h3000 and `fetch_cnt`=0 immediately. `npc_sel`=X with `pcwr`=0 on any cycle leaves `pc` unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Purpose  : Shared encodings and defaults for the multicycle MIPS core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  // Next-PC source select driven by the multicycle controller
  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  // Controller states; S0 is the fetch state that pulses pcwr and irwr together
  typedef enum logic [3:0] {
    S0_FETCH   = 4'd0,
    S1_DECODE  = 4'd1,
    S2_MEMADR  = 4'd2,
    S3_MEMRD   = 4'd3,
    S4_MEMWB   = 4'd4,
    S5_MEMWR   = 4'd5,
    S6_EXEC    = 4'd6,
    S7_ALUWB   = 4'd7,
    S8_BRANCH  = 4'd8,
    S9_JUMP    = 4'd9
  } ctrl_state_e;

  // Word offset of a branch immediate, sign-extended and scaled to bytes
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage : mips_pkg

`default_nettype wire

// File: rtl/npc.sv
// ============================================================================
// Module   : npc
// Purpose  : Combinational next-PC selection and target alignment check.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module npc
  import mips_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [31:0] instr,
  input  logic [31:0] rs_data,
  input  logic [1:0]  npc_sel,
  output logic [31:0] npc,
  output logic        npc_misaligned
);

  // Opcode field is decoded by the controller, not here
  logic w_unused_opcode;
  assign w_unused_opcode = ^instr[31:26];

  always_comb begin
    npc = pc + 32'd4;
    case (npc_sel)
      NPC_PC4: npc = pc + 32'd4;
      NPC_BR:  npc = pc + branch_offset(instr[15:0]);
      NPC_J:   npc = {pc[31:28], instr[25:0], 2'b00};
      NPC_JR:  npc = rs_data;
      default: npc = pc + 32'd4;
    endcase
  end

  // Only the register path can deliver a non-word-aligned target
  assign npc_misaligned = |npc[1:0];

endmodule : npc

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
// Module   : fetch_unit
// Purpose  : PC, instruction register, next-PC update and fetch bring-up aids.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          IM_AW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pcwr,
  input  logic             irwr,
  input  logic [1:0]       npc_sel,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      imem_rdata,
  output logic [IM_AW-1:0] imem_addr,
  output logic [31:0]      instr,
  output logic [31:0]      pc,
  output logic [31:0]      link,
  output logic             misalign,
  output logic [31:0]      fetch_cnt
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        misalign_q, misalign_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  logic [31:0] w_npc;
  logic        w_npc_misaligned;

  npc u_npc (
    .pc             (pc_q),
    .instr          (instr_q),
    .rs_data        (rs_data),
    .npc_sel        (npc_sel),
    .npc            (w_npc),
    .npc_misaligned (w_npc_misaligned)
  );

  // pcwr gates every use of npc so an undefined npc_sel cannot leak into state
  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    misalign_d  = misalign_q;
    fetch_cnt_d = fetch_cnt_q;
    if (pcwr) begin
      if (w_npc_misaligned) begin
        misalign_d = 1'b1;
      end else begin
        pc_d = w_npc;
      end
    end
    if (irwr) begin
      instr_d     = imem_rdata;
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      instr_q     <= 32'd0;
      misalign_q  <= 1'b0;
      fetch_cnt_q <= 32'd0;
    end else begin
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      misalign_q  <= misalign_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // After S0 the PC already holds fetch-PC+4, which is the return address
  assign imem_addr = pc_q[IM_AW+1:2];
  assign instr     = instr_q;
  assign pc        = pc_q;
  assign link      = pc_q;
  assign misalign  = misalign_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule : fetch_unit

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Directed vector table plus randomized run against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcwr, irwr;
  logic [1:0]  npc_sel;
  logic [31:0] rs_data, imem_rdata;
  logic [9:0]  imem_addr;
  logic [31:0] instr, pc, link, fetch_cnt;
  logic        misalign;

  logic [31:0] rom [0:1023];
  assign imem_rdata = rom[imem_addr];

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0000_3000), .IM_AW(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .pcwr       (pcwr),
    .irwr       (irwr),
    .npc_sel    (npc_sel),
    .rs_data    (rs_data),
    .imem_rdata (imem_rdata),
    .imem_addr  (imem_addr),
    .instr      (instr),
    .pc         (pc),
    .link       (link),
    .misalign   (misalign),
    .fetch_cnt  (fetch_cnt)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ir,
                           input logic e_mis, input logic [31:0] e_cnt);
    chk({tag, ".pc"},        pc,               e_pc);
    chk({tag, ".link"},      link,             e_pc);
    chk({tag, ".instr"},     instr,            e_ir);
    chk({tag, ".misalign"},  {31'd0, misalign}, {31'd0, e_mis});
    chk({tag, ".fetch_cnt"}, fetch_cnt,        e_cnt);
    chk({tag, ".imem_addr"}, {22'd0, imem_addr}, (e_pc / 4) % 1024);
  endtask

  // Apply one set of strobes for exactly one rising edge; called at posedge+1
  task automatic cycle(input logic pw, input logic iw, input logic [1:0] sel, input logic [31:0] rs);
    pcwr    = pw;
    irwr    = iw;
    npc_sel = sel;
    rs_data = rs;
    @(posedge clk);
    #1;
    pcwr = 1'b0;
    irwr = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        pw;
    logic        iw;
    logic [1:0]  sel;
    logic [31:0] rs;
    logic [31:0] e_pc;
    logic [31:0] e_ir;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(string n, logic pw, logic iw, logic [1:0] sel, logic [31:0] rs,
                              logic [31:0] e_pc, logic [31:0] e_ir, logic e_mis, logic [31:0] e_cnt);
    vec_t v;
    v.name = n; v.pw = pw; v.iw = iw; v.sel = sel; v.rs = rs;
    v.e_pc = e_pc; v.e_ir = e_ir; v.e_mis = e_mis; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Reference model: architectural state updated from the rules with plain arithmetic
  logic [31:0] m_pc, m_ir, m_cnt;
  logic        m_mis;

  task automatic model_reset();
    m_pc = 32'h0000_3000; m_ir = 32'd0; m_cnt = 32'd0; m_mis = 1'b0;
  endtask

  task automatic model_step(input logic pw, input logic iw, input logic [1:0] sel, input logic [31:0] rs);
    logic [31:0] tgt;
    logic [31:0] fetched;
    int          off;
    fetched = rom[(m_pc / 4) % 1024];
    off = $signed(m_ir[15:0]);
    case (sel)
      2'd0:    tgt = m_pc + 4;
      2'd1:    tgt = m_pc + 32'(off * 4);
      2'd2:    tgt = (m_pc & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 4);
      default: tgt = rs;
    endcase
    if (pw) begin
      if (tgt % 4 != 0) m_mis = 1'b1;
      else              m_pc  = tgt;
    end
    if (iw) begin
      m_ir  = fetched;
      m_cnt = m_cnt + 1;
    end
  endtask

  vec_t vt[$];

  initial begin
    rst = 1'b1; pcwr = 1'b0; irwr = 1'b0; npc_sel = 2'b00; rs_data = 32'd0;
    for (int i = 0; i < 1024; i++) rom[i] = 32'd0;
    rom[0] = 32'h3401_0005;
    rom[1] = 32'h1000_FFFE;
    rom[2] = 32'h2402_0007;
    rom[3] = 32'h0800_0C10;
    rom[8] = 32'hAC01_0000;

    vt.push_back(mk("reset_fetch",  1, 1, 2'b00, 32'h0,    32'h3004, 32'h3401_0005, 0, 1));
    vt.push_back(mk("fetch_beq",    1, 1, 2'b00, 32'h0,    32'h3008, 32'h1000_FFFE, 0, 2));
    vt.push_back(mk("branch_nopcw", 0, 0, 2'b01, 32'h0,    32'h3008, 32'h1000_FFFE, 0, 2));
    vt.push_back(mk("branch",       1, 0, 2'b01, 32'h0,    32'h3000, 32'h1000_FFFE, 0, 2));
    vt.push_back(mk("refetch0",     1, 1, 2'b00, 32'h0,    32'h3004, 32'h3401_0005, 0, 3));
    vt.push_back(mk("refetch1",     1, 1, 2'b00, 32'h0,    32'h3008, 32'h1000_FFFE, 0, 4));
    vt.push_back(mk("refetch2",     1, 1, 2'b00, 32'h0,    32'h300C, 32'h2402_0007, 0, 5));
    vt.push_back(mk("fetch_j",      1, 1, 2'b00, 32'h0,    32'h3010, 32'h0800_0C10, 0, 6));
    vt.push_back(mk("jump",         1, 0, 2'b10, 32'h0,    32'h3040, 32'h0800_0C10, 0, 6));
    vt.push_back(mk("jr_aligned",   1, 0, 2'b11, 32'h3020, 32'h3020, 32'h0800_0C10, 0, 6));
    vt.push_back(mk("jr_misalign",  1, 0, 2'b11, 32'h3022, 32'h3020, 32'h0800_0C10, 1, 6));
    vt.push_back(mk("sticky_fetch", 1, 1, 2'b00, 32'h0,    32'h3024, 32'hAC01_0000, 1, 7));
    vt.push_back(mk("idle_hold",    0, 0, 2'b11, 32'h3022, 32'h3024, 32'hAC01_0000, 1, 7));
    vt.push_back(mk("sel_x_hold",   0, 0, 2'bxx, 32'h0,    32'h3024, 32'hAC01_0000, 1, 7));

    @(posedge clk);
    #1;
    chk_state("reset", 32'h3000, 32'd0, 1'b0, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      cycle(vt[i].pw, vt[i].iw, vt[i].sel, vt[i].rs);
      chk_state(vt[i].name, vt[i].e_pc, vt[i].e_ir, vt[i].e_mis, vt[i].e_cnt);
    end

    // Five more fetches, then reset between edges: state must clear with no clock
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 2'b00, 32'd0);
    chk("pre_reset.fetch_cnt", fetch_cnt, 32'd12);
    #3 rst = 1'b1;
    #1;
    chk_state("async_reset", 32'h3000, 32'd0, 1'b0, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(1'b1, 1'b1, 2'b00, 32'd0);
    chk_state("post_reset_fetch", 32'h3004, 32'h3401_0005, 1'b0, 32'd1);

    // Randomized run against the reference model, with occasional async resets
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    chk_state("rand_reset", m_pc, m_ir, m_mis, m_cnt);
    for (int n = 0; n < 600; n++) begin
      logic        pw, iw;
      logic [1:0]  sel;
      logic [31:0] rs;
      pw  = 1'($urandom_range(0, 1));
      iw  = 1'($urandom_range(0, 1));
      sel = 2'($urandom_range(0, 3));
      rs  = $urandom;
      if ($urandom_range(0, 7) != 0) rs[1:0] = 2'b00;
      model_step(pw, iw, sel, rs);
      cycle(pw, iw, sel, rs);
      chk_state("random", m_pc, m_ir, m_mis, m_cnt);
      if (n % 97 == 96) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_state("rand_async_reset", m_pc, m_ir, m_mis, m_cnt);
        rst = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_fetch_unit

`default_nettype wire
